// File: rtl/multitap_delay.sv
// Multi-tap circular-buffer delay line: stores each accepted sample, reads
// N_TAPS offset taps through one registered RAM port, and emits taps plus a saturated mix.
//
// state | meaning
// IDLE  | waiting for an input sample (in_ready=1)
// READ  | issuing one tap address per cycle
// DRAIN | capturing the last tap, computing mix
// OUT   | result presented until out_ready
module multitap_delay #(
  parameter int A_WIDTH    = 9,
  parameter int D_WIDTH    = 8,
  parameter int N_TAPS     = 4,
  parameter int GAIN_SHIFT = 2
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [D_WIDTH-1:0]          din,
  input  logic [N_TAPS*A_WIDTH-1:0]   offsets,
  input  logic [N_TAPS-1:0]           tap_en,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [N_TAPS*D_WIDTH-1:0]   taps_out,
  output logic [D_WIDTH-1:0]          mix_out
);

  localparam int DEPTH = 1 << A_WIDTH;
  localparam int CW    = (N_TAPS > 1) ? $clog2(N_TAPS) : 1;
  localparam logic [CW-1:0]      LAST_IDX = CW'(N_TAPS - 1);
  localparam logic [A_WIDTH:0]   FILL_MAX = {1'b1, {A_WIDTH{1'b0}}};
  localparam logic [D_WIDTH+3:0] MIX_MAX  = {4'b0000, {D_WIDTH{1'b1}}};

  typedef enum logic [1:0] {IDLE, READ, DRAIN, OUT} state_t;

  state_t                      state_q, state_d;
  logic [A_WIDTH-1:0]          wr_ptr_q, wr_ptr_d;
  logic [A_WIDTH:0]            fill_q, fill_d;
  logic [A_WIDTH-1:0]          p_q, p_d;
  logic [D_WIDTH-1:0]          din_lat_q, din_lat_d;
  logic [N_TAPS*A_WIDTH-1:0]   off_lat_q, off_lat_d;
  logic [N_TAPS-1:0]           en_lat_q, en_lat_d;
  logic [CW-1:0]               idx_q, idx_d;
  logic [CW-1:0]               cap_idx_q, cap_idx_d;
  logic                        cap_vld_q, cap_vld_d;
  logic [N_TAPS*D_WIDTH-1:0]   tap_w_q, tap_w_d;
  logic [N_TAPS*D_WIDTH-1:0]   taps_q, taps_d;
  logic [D_WIDTH-1:0]          mix_q, mix_d;
  logic                        out_valid_q, out_valid_d;

  logic [D_WIDTH-1:0]          mem [DEPTH];
  logic [D_WIDTH-1:0]          ram_rd_q;
  logic [A_WIDTH-1:0]          rd_addr;
  logic [A_WIDTH-1:0]          cap_off;
  logic [D_WIDTH-1:0]          cap_val;
  logic                        accept;
  logic [D_WIDTH+2:0]          sum;
  logic [D_WIDTH+2:0]          sum_sh;
  logic [D_WIDTH+3:0]          mix_wide;

  assign in_ready  = (state_q == IDLE) && !rst;
  assign accept    = in_valid && in_ready;
  assign out_valid = out_valid_q;
  assign taps_out  = taps_q;
  assign mix_out   = mix_q;

  assign rd_addr = p_q - off_lat_q[idx_q*A_WIDTH +: A_WIDTH];
  assign cap_off = off_lat_q[cap_idx_q*A_WIDTH +: A_WIDTH];

  // RAM has no reset: history survives rst, the fill count masks it instead.
  always_ff @(posedge clk) begin
    if (accept) mem[wr_ptr_q] <= din;
    if (state_q == READ) ram_rd_q <= mem[rd_addr];
  end

  always_comb begin
    cap_val = ram_rd_q;
    if (cap_off == '0)
      cap_val = din_lat_q;
    else if ({1'b0, cap_off} >= fill_q)
      cap_val = '0;
  end

  always_comb begin
    state_d     = state_q;
    wr_ptr_d    = wr_ptr_q;
    fill_d      = fill_q;
    p_d         = p_q;
    din_lat_d   = din_lat_q;
    off_lat_d   = off_lat_q;
    en_lat_d    = en_lat_q;
    idx_d       = idx_q;
    cap_idx_d   = idx_q;
    cap_vld_d   = (state_q == READ);
    tap_w_d     = tap_w_q;
    taps_d      = taps_q;
    mix_d       = mix_q;
    out_valid_d = out_valid_q;
    sum         = '0;
    sum_sh      = '0;
    mix_wide    = '0;

    if (cap_vld_q) tap_w_d[cap_idx_q*D_WIDTH +: D_WIDTH] = cap_val;

    case (state_q)
      IDLE: begin
        if (accept) begin
          din_lat_d = din;
          off_lat_d = offsets;
          en_lat_d  = tap_en;
          p_d       = wr_ptr_q;
          wr_ptr_d  = wr_ptr_q + 1'b1;
          fill_d    = (fill_q == FILL_MAX) ? fill_q : fill_q + 1'b1;
          idx_d     = '0;
          state_d   = READ;
        end
      end
      READ: begin
        idx_d = idx_q + 1'b1;
        if (idx_q == LAST_IDX) state_d = DRAIN;
      end
      DRAIN: begin
        for (int k = 0; k < N_TAPS; k++) begin
          if (en_lat_q[k]) sum = sum + {3'b000, tap_w_d[k*D_WIDTH +: D_WIDTH]};
        end
        sum_sh   = sum >> GAIN_SHIFT;
        mix_wide = {4'b0000, din_lat_q} + {1'b0, sum_sh};
        mix_d    = (mix_wide > MIX_MAX) ? {D_WIDTH{1'b1}} : mix_wide[D_WIDTH-1:0];
        taps_d      = tap_w_d;
        out_valid_d = 1'b1;
        state_d     = OUT;
      end
      OUT: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      wr_ptr_q    <= '0;
      fill_q      <= '0;
      p_q         <= '0;
      din_lat_q   <= '0;
      off_lat_q   <= '0;
      en_lat_q    <= '0;
      idx_q       <= '0;
      cap_idx_q   <= '0;
      cap_vld_q   <= 1'b0;
      tap_w_q     <= '0;
      taps_q      <= '0;
      mix_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      fill_q      <= fill_d;
      p_q         <= p_d;
      din_lat_q   <= din_lat_d;
      off_lat_q   <= off_lat_d;
      en_lat_q    <= en_lat_d;
      idx_q       <= idx_d;
      cap_idx_q   <= cap_idx_d;
      cap_vld_q   <= cap_vld_d;
      tap_w_q     <= tap_w_d;
      taps_q      <= taps_d;
      mix_q       <= mix_d;
      out_valid_q <= out_valid_d;
    end
  end

endmodule

// File: tb/tb_multitap_delay.sv
// Directed bench for multitap_delay (16-deep buffer, 4 taps): behavioural
// history model feeds a scoreboard queue that is checked on each output.
module tb_multitap_delay;

  localparam int AW = 4;
  localparam int DW = 8;
  localparam int NT = 4;
  localparam int GS = 2;
  localparam int DEP = 1 << AW;

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic [DW-1:0]     din;
  logic [NT*AW-1:0]  offsets;
  logic [NT-1:0]     tap_en;
  logic              out_valid;
  logic              out_ready;
  logic [NT*DW-1:0]  taps_out;
  logic [DW-1:0]     mix_out;

  always #5 clk = ~clk;

  multitap_delay #(.A_WIDTH(AW), .D_WIDTH(DW), .N_TAPS(NT), .GAIN_SHIFT(GS)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .din(din),
    .offsets(offsets), .tap_en(tap_en), .out_valid(out_valid), .out_ready(out_ready),
    .taps_out(taps_out), .mix_out(mix_out)
  );

  typedef struct packed {
    logic [NT*DW-1:0] taps;
    logic [DW-1:0]    mix;
  } exp_t;

  exp_t          exp_q[$];
  logic [DW-1:0] hist [DEP];
  int            m_wp;
  int            m_fill;
  int            checks = 0;
  int            failures = 0;
  int            lat;
  logic [31:0]   ot;
  logic [7:0]    om;
  logic [31:0]   hold_taps;
  logic [7:0]    hold_mix;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, expv);
    end
  endtask

  task automatic model_reset();
    m_wp = 0;
    m_fill = 0;
    exp_q.delete();
  endtask

  task automatic model_accept(input logic [DW-1:0] d, input logic [NT*AW-1:0] offs,
                              input logic [NT-1:0] en);
    int   p, sum, mix, off;
    logic [DW-1:0] t;
    exp_t e;
    hist[m_wp] = d;
    p = m_wp;
    m_wp = (m_wp + 1) % DEP;
    if (m_fill < DEP) m_fill++;
    sum = 0;
    for (int k = 0; k < NT; k++) begin
      off = int'(offs[k*AW +: AW]);
      if (off == 0)            t = d;
      else if (off >= m_fill)  t = '0;
      else                     t = hist[(p - off) & (DEP - 1)];
      e.taps[k*DW +: DW] = t;
      if (en[k]) sum += int'(t);
    end
    mix = int'(d) + (sum >> GS);
    if (mix > 255) mix = 255;
    e.mix = DW'(mix);
    exp_q.push_back(e);
  endtask

  task automatic send(input logic [DW-1:0] d, input logic [NT*AW-1:0] offs,
                      input logic [NT-1:0] en);
    int n;
    @(negedge clk);
    in_valid = 1'b1;
    din = d;
    offsets = offs;
    tap_en = en;
    n = 0;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      chk("accept_timeout", {31'b0, in_ready}, 32'd1);
      in_valid = 1'b0;
    end else begin
      model_accept(d, offs, en);
      @(posedge clk);
      #1 in_valid = 1'b0;
    end
  endtask

  task automatic recv(output int l, output logic [31:0] o_taps, output logic [7:0] o_mix);
    exp_t e;
    l = 0;
    do begin
      @(negedge clk);
      l++;
    end while (!out_valid && l < 30);
    o_taps = taps_out;
    o_mix  = mix_out;
    if (!out_valid) begin
      chk("out_timeout", {31'b0, out_valid}, 32'd1);
    end else if (exp_q.size() == 0) begin
      chk("sb_underflow", 32'(exp_q.size()), 32'd1);
    end else begin
      e = exp_q.pop_front();
      chk("taps", taps_out, e.taps);
      chk("mix", {24'b0, mix_out}, {24'b0, e.mix});
      @(posedge clk);
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; din = '0; offsets = '0; tap_en = '0; out_ready = 1'b1;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", {31'b0, in_ready}, 32'd0);
    chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_taps", taps_out, 32'd0);
    chk("rst_mix", {24'b0, mix_out}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_in_ready", {31'b0, in_ready}, 32'd1);

    // Basic ramp with offsets {0,1,2,3}
    for (int i = 1; i <= 4; i++) begin
      send(DW'(i), 16'h3210, 4'hF);
      recv(lat, ot, om);
      if (i == 1) begin
        chk("latency", 32'(lat), 32'(NT + 2));
        chk("s1_taps", ot, 32'h0000_0001);
      end
      if (i == 4) begin
        chk("s4_taps", ot, 32'h0102_0304);
        chk("s4_mix", {24'b0, om}, 32'd6);
      end
    end

    // Pointer wrap with the maximum offset on tap 0
    @(negedge clk); rst = 1'b1; model_reset();
    @(negedge clk); rst = 1'b0;
    for (int i = 1; i <= 40; i++) begin
      send(DW'(i), 16'h000F, 4'b0001);
      recv(lat, ot, om);
      if (i == 15) chk("wrap_s15_tap0", {24'b0, ot[7:0]}, 32'd0);
      if (i == 40) chk("wrap_s40_tap0", {24'b0, ot[7:0]}, 32'd25);
    end

    // Saturation
    for (int i = 0; i < DEP; i++) begin
      send(8'd255, 16'h0000, 4'h0);
      recv(lat, ot, om);
    end
    send(8'd200, 16'h1111, 4'hF);
    recv(lat, ot, om);
    chk("sat_mix", {24'b0, om}, 32'd255);
    send(8'd200, 16'h1111, 4'h0);
    recv(lat, ot, om);
    chk("noen_mix", {24'b0, om}, 32'd200);

    // Backpressure: result held, stray input refused
    @(negedge clk); out_ready = 1'b0;
    send(8'd9, 16'h0001, 4'h1);
    recv(lat, ot, om);
    hold_taps = taps_out;
    hold_mix  = mix_out;
    in_valid = 1'b1; din = 8'd99;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      chk("bp_out_valid", {31'b0, out_valid}, 32'd1);
      chk("bp_taps_stable", taps_out, hold_taps);
      chk("bp_mix_stable", {24'b0, mix_out}, {24'b0, hold_mix});
      chk("bp_in_ready", {31'b0, in_ready}, 32'd0);
    end
    out_ready = 1'b1; in_valid = 1'b0;
    @(negedge clk);
    chk("bp_release_valid", {31'b0, out_valid}, 32'd0);
    chk("bp_release_ready", {31'b0, in_ready}, 32'd1);
    send(8'd10, 16'h0001, 4'h1);
    recv(lat, ot, om);
    chk("bp_next_tap0", {24'b0, ot[7:0]}, 32'd9);

    // Reset while the FSM is in READ
    send(8'd50, 16'h0001, 4'h1);
    @(negedge clk);
    rst = 1'b1;
    model_reset();
    @(negedge clk);
    chk("midrst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("midrst_in_ready", {31'b0, in_ready}, 32'd0);
    rst = 1'b0;
    repeat (8) @(negedge clk);
    chk("midrst_no_output", {31'b0, out_valid}, 32'd0);
    send(8'd77, 16'h0001, 4'h1);
    recv(lat, ot, om);
    chk("midrst_tap0_zero", {24'b0, ot[7:0]}, 32'd0);

    // Inputs changed while the sample is in flight
    send(8'd5, 16'h0321, 4'hF);
    offsets = 16'hFFFF; tap_en = 4'h0; din = 8'd0;
    recv(lat, ot, om);
    chk("latched_taps", ot, 32'h0500_004D);
    chk("latched_mix", {24'b0, om}, 32'd25);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
